udma_evt_collector: RTL and testbench



---
 rtl/udma_evt_collector.sv | 158 +++++++++++++++
 tb/tb_udma_evt_collector.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/udma_evt_collector.sv
// uDMA event collector: per-line saturating pending counters, round-robin arbiter, FWFT output FIFO.
// Optional drop statistics counter enabled by defining UDMA_EVT_COLLECTOR_STATS_EN.
module udma_evt_collector #(
    parameter int N_PERIPHS     = 32,
    parameter int CNT_W         = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int EVT_ID_OFFSET = 0
) (
    input  logic                      sys_clk_i,
    input  logic                      sys_rst_i,
    input  logic [N_PERIPHS-1:0][3:0] events_i,
    input  logic [4*N_PERIPHS-1:0]    evt_mask_i,
    output logic                      evt_valid_o,
    output logic [7:0]                evt_data_o,
    input  logic                      evt_ready_i,
    output logic                      drop_o,
    output logic [7:0]                drop_id_o,
    output logic                      busy_o
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
    ,
    output logic [15:0]               drop_cnt_o,
    input  logic                      drop_cnt_clr_i
`endif
);

    localparam int N_EVT = 4 * N_PERIPHS;
    localparam int PTR_W = $clog2(N_EVT);
    localparam int FA_W  = $clog2(FIFO_DEPTH);

    if (EVT_ID_OFFSET + N_EVT > 256) begin : g_id_range_chk
        $error("EVT_ID_OFFSET + N_EVT must not exceed 256");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_fifo_depth_chk
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] to_id(input logic [PTR_W-1:0] line);
        return 8'(EVT_ID_OFFSET + int'(line));
    endfunction

    logic [N_EVT-1:0]            ev_flat;
    logic [N_EVT-1:0]            inc;
    logic [N_EVT-1:0]            dec;
    logic [N_EVT-1:0][CNT_W-1:0] cnt;
    logic [PTR_W-1:0]            rr_ptr;
    logic                        gnt_vld;
    logic [PTR_W-1:0]            gnt_idx;
    int                          idx;
    logic                        drop_any;
    logic [PTR_W-1:0]            drop_line;

    logic [7:0]                  mem [FIFO_DEPTH];
    logic [FA_W-1:0]             wr_ptr;
    logic [FA_W-1:0]             rd_ptr;
    logic [FA_W:0]               fcount;
    logic                        fifo_full;
    logic                        push;
    logic                        pop;

    assign ev_flat = events_i;
    assign inc     = ev_flat & ~evt_mask_i;

    // Arbitration: first nonzero counter at or after rr_ptr, only while the FIFO has room
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 0; k < N_EVT; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_EVT) idx = idx - N_EVT;
            if (!gnt_vld && !fifo_full && cnt[idx] != '0) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        dec = '0;
        if (gnt_vld) dec[gnt_idx] = 1'b1;
    end

    // Descending scan leaves the lowest dropping line in drop_line
    always_comb begin
        drop_any  = 1'b0;
        drop_line = '0;
        for (int l = N_EVT - 1; l >= 0; l--) begin
            if (inc[l] && !dec[l] && cnt[l] == '1) begin
                drop_any  = 1'b1;
                drop_line = PTR_W'(l);
            end
        end
    end

    // Counter / pointer stage
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            cnt    <= '0;
            rr_ptr <= '0;
        end else begin
            for (int l = 0; l < N_EVT; l++) begin
                if (inc[l] && !dec[l])      cnt[l] <= sat_inc(cnt[l]);
                else if (dec[l] && !inc[l]) cnt[l] <= cnt[l] - 1'b1;
            end
            if (gnt_vld)
                rr_ptr <= (gnt_idx == PTR_W'(N_EVT - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Output FIFO stage
    assign fifo_full   = (fcount == (FA_W + 1)'(FIFO_DEPTH));
    assign push        = gnt_vld;
    assign pop         = evt_valid_o & evt_ready_i;
    assign evt_valid_o = (fcount != '0);
    assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge sys_clk_i) begin
        if (push) mem[wr_ptr] <= to_id(gnt_idx);
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fcount <= fcount + 1'b1;
            else if (pop && !push) fcount <= fcount - 1'b1;
        end
    end

    // Drop report stage
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            drop_o    <= 1'b0;
            drop_id_o <= 8'h00;
        end else begin
            drop_o <= drop_any;
            if (drop_any) drop_id_o <= to_id(drop_line);
        end
    end

    assign busy_o = (fcount != '0) || (|cnt);

`ifdef UDMA_EVT_COLLECTOR_STATS_EN
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || drop_cnt_clr_i) drop_cnt_o <= 16'h0000;
        else if (drop_any && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'h0001;
    end
`endif

endmodule

// File: tb/tb_udma_evt_collector.sv
// Scoreboard bench for udma_evt_collector: directed pulses, expected IDs queued, monitor checks outputs.
module tb_udma_evt_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] ev = '0;
    logic [127:0] mask = '0;
    logic         ready = 1'b1;
    logic         evt_valid;
    logic [7:0]   evt_data;
    logic         drop;
    logic [7:0]   drop_id;
    logic         busy;
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
    logic [15:0]  drop_cnt;
    logic         drop_cnt_clr = 1'b0;
`endif

    typedef struct {
        logic [7:0] id;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   drops_seen = 0;
    int   d0;

    udma_evt_collector dut (
        .sys_clk_i      (clk),
        .sys_rst_i      (rst),
        .events_i       (ev),
        .evt_mask_i     (mask),
        .evt_valid_o    (evt_valid),
        .evt_data_o     (evt_data),
        .evt_ready_i    (ready),
        .drop_o         (drop),
        .drop_id_o      (drop_id),
        .busy_o         (busy)
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
        ,
        .drop_cnt_o     (drop_cnt),
        .drop_cnt_clr_i (drop_cnt_clr)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every accepted output is compared against the queue head
    always @(negedge clk) begin
        if (drop) drops_seen = drops_seen + 1;
        if (!rst && evt_valid && ready) begin
            n_checks = n_checks + 1;
            if (q.size() == 0) begin
                n_fail = n_fail + 1;
                $display("FAIL unexpected_out: got id %0d at cycle %0d, required no output", evt_data, cyc);
            end else begin
                e = q.pop_front();
                if (evt_data !== e.id || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_fail = n_fail + 1;
                    $display("FAIL out_id: got id %0d at cycle %0d, required id %0d at cycle %0d",
                             evt_data, cyc, e.id, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks = n_checks + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_id(input logic [7:0] id, input int at_cyc);
        exp_t x;
        x.id  = id;
        x.cyc = at_cyc;
        q.push_back(x);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        n_checks = n_checks + 1;
        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain: %0d outputs outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_data", 32'(evt_data), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_drop_id", 32'(drop_id), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
        check("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        rst = 1'b0;

        // Single pulse on line 5, latency 2, one output
        ev[5] = 1'b1;
        expect_id(8'd5, cyc + 2);
        tick();
        ev = '0;
        check("single_busy_pending", 32'(busy), 1);
        tick();
        tick();
        check("single_busy_after", 32'(busy), 0);
        check("single_valid_after", 32'(evt_valid), 0);
        drain(5);

        // Simultaneous pulses on 3, 10, 127 from pointer 0
        reset_dut();
        ev[3] = 1'b1; ev[10] = 1'b1; ev[127] = 1'b1;
        expect_id(8'd3, cyc + 2);
        expect_id(8'd10, cyc + 3);
        expect_id(8'd127, cyc + 4);
        tick();
        ev = '0;
        drain(10);

        // Line 0 saturation: 4 FIFO entries + counter at 3, 8th pulse drops
        reset_dut();
        ready = 1'b0;
        ev[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("sat_no_drop_yet", 32'(drop), 0);
            tick();
        end
        ev = '0;
        check("sat_drop", 32'(drop), 1);
        check("sat_drop_id", 32'(drop_id), 0);
        check("sat_head_valid", 32'(evt_valid), 1);
        tick();
        check("sat_drop_pulse_end", 32'(drop), 0);
        check("sat_busy", 32'(busy), 1);
        for (int i = 0; i < 7; i++) expect_id(8'd0, -1);
        ready = 1'b1;
        drain(40);
        tick();
        check("sat_busy_end", 32'(busy), 0);

        // Fairness between lines 2 and 4
        reset_dut();
        d0 = drops_seen;
        ev[2] = 1'b1; ev[4] = 1'b1;
        for (int i = 0; i < 6; i++) expect_id((i % 2 == 0) ? 8'd2 : 8'd4, cyc + 2 + i);
        tick();
        tick();
        tick();
        ev = '0;
        drain(20);
        check("fair_no_drops", 32'(drops_seen - d0), 0);

        // Masked line 6 is ignored; unmasked pulse is delivered
        d0 = drops_seen;
        mask[6] = 1'b1;
        ev[6] = 1'b1;
        tick();
        ev = '0;
        tick();
        tick();
        tick();
        check("mask_busy", 32'(busy), 0);
        check("mask_no_drop", 32'(drops_seen - d0), 0);
        mask[6] = 1'b0;
        ev[6] = 1'b1;
        expect_id(8'd6, cyc + 2);
        tick();
        ev = '0;
        drain(10);

        // Pending count on a line masked after the pulse still drains
        ev[7] = 1'b1;
        expect_id(8'd7, cyc + 2);
        tick();
        ev = '0;
        mask[7] = 1'b1;
        drain(10);
        mask = '0;

        // Reset mid-operation with queued and pending events
        reset_dut();
        ready = 1'b0;
        ev[20] = 1'b1; ev[21] = 1'b1; ev[22] = 1'b1; ev[23] = 1'b1; ev[30] = 1'b1;
        tick();
        ev = '0;
        tick();
        tick();
        tick();
        check("midrst_pre_valid", 32'(evt_valid), 1);
        check("midrst_pre_head", 32'(evt_data), 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(evt_valid), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_data", 32'(evt_data), 0);
        ready = 1'b1;
        ev[9] = 1'b1;
        expect_id(8'd9, cyc + 2);
        tick();
        ev = '0;
        drain(10);

        // Simultaneous drops on 40 and 50: lowest reported, held afterwards
        reset_dut();
        ready = 1'b0;
        ev[40] = 1'b1; ev[50] = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("multi_drop", 32'(drop), 1);
        check("multi_drop_id", 32'(drop_id), 40);
        tick();
        tick();
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
        check("stats_cnt3", 32'(drop_cnt), 3);
        drop_cnt_clr = 1'b1;
`endif
        tick();
        ev = '0;
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
        drop_cnt_clr = 1'b0;
        check("stats_clr_prio", 32'(drop_cnt), 0);
`endif
        check("multi_drop_last", 32'(drop), 1);
        tick();
        check("multi_drop_end", 32'(drop), 0);
        check("multi_drop_id_held", 32'(drop_id), 40);
`ifdef UDMA_EVT_COLLECTOR_STATS_EN
        check("stats_cnt_stays0", 32'(drop_cnt), 0);
`endif
        for (int i = 0; i < 10; i++) expect_id((i % 2 == 0) ? 8'd40 : 8'd50, -1);
        ready = 1'b1;
        drain(60);
        tick();
        check("multi_busy_end", 32'(busy), 0);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
